dcache_flush_seq: RTL

Flush/invalidate sequencer for the non-blocking L1 data cache. On a flush request it walks every set of the valid/dirty/tag arrays through one requester port of the SRAM arbiter. It hands each valid-and-dirty way to the miss handler's write-back path, then clears valid/dirty for the whole set. It sits beside the per-port cache controllers as an additional arbiter master and replaces the flush walk inside the miss handler.

---
 rtl/dcache_flush_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dcache_flush_seq.sv
// Flush/invalidate sequencer: walks every set of the valid/dirty/tag arrays,
// hands valid+dirty ways to the write-back path, then clears the whole set.
module dcache_flush_seq #(
  parameter int SET_ASSOC   = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int BYTE_OFFSET = 4,
  parameter int TAG_WIDTH   = 44
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              inval_only_i,
  input  logic                              busy_i,
  output logic                              active_o,
  output logic                              flush_ack_o,
  output logic [SET_ASSOC-1:0]              req_o,
  output logic [INDEX_WIDTH-1:0]            addr_o,
  output logic                              we_o,
  output logic [SET_ASSOC-1:0]              be_o,
  input  logic                              gnt_i,
  input  logic [SET_ASSOC-1:0]              vld_i,
  input  logic [SET_ASSOC-1:0]              dirty_i,
  input  logic [SET_ASSOC*TAG_WIDTH-1:0]    tag_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  wb_addr_o,
  output logic [$clog2(SET_ASSOC)-1:0]      wb_way_o,
  input  logic                              wb_done_i
);

  localparam int SET_W    = INDEX_WIDTH - BYTE_OFFSET;
  localparam int NUM_SETS = 2 ** SET_W;
  localparam int WAY_W    = $clog2(SET_ASSOC);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EVAL, S_WB, S_WB_WAIT, S_CLEAR, S_DONE
  } state_t;

  state_t                                 state_q, state_d;
  logic [SET_W-1:0]                       set_idx_q, set_idx_d;
  logic [SET_ASSOC-1:0]                   pend_q, pend_d;
  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]    tags_q, tags_d;
  logic                                   inval_q, inval_d;
  logic [WAY_W-1:0]                       wb_way;
  logic [SET_ASSOC-1:0]                   pend_clr;

  // Lowest pending way is served first; scanning downward leaves the lowest hit.
  always_comb begin
    wb_way = '0;
    for (int w = SET_ASSOC - 1; w >= 0; w--) begin
      if (pend_q[w]) wb_way = WAY_W'(w);
    end
  end

  assign pend_clr = pend_q & ~(SET_ASSOC'(1) << wb_way);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      set_idx_q <= '0;
      pend_q    <= '0;
      inval_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_idx_q <= set_idx_d;
      pend_q    <= pend_d;
      inval_q   <= inval_d;
    end
  end

  // Tags are only consumed while pend_q marks them, so they need no reset.
  always_ff @(posedge clk_i) begin
    tags_q <= tags_d;
  end

  always_comb begin
    state_d   = state_q;
    set_idx_d = set_idx_q;
    pend_d    = pend_q;
    tags_d    = tags_q;
    inval_d   = inval_q;
    case (state_q)
      S_IDLE: begin
        set_idx_d = '0;
        inval_d   = inval_only_i;
        if (flush_i && !busy_i) state_d = S_READ;
      end
      S_READ: begin
        if (gnt_i) state_d = S_EVAL;
      end
      S_EVAL: begin
        pend_d  = vld_i & dirty_i & {SET_ASSOC{~inval_q}};
        tags_d  = tag_i;
        state_d = (pend_d != '0) ? S_WB : S_CLEAR;
      end
      S_WB: begin
        if (wb_ready_i) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (wb_done_i) begin
          pend_d  = pend_clr;
          state_d = (pend_clr != '0) ? S_WB : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (gnt_i) begin
          if (set_idx_q == SET_W'(NUM_SETS - 1)) begin
            state_d = S_DONE;
          end else begin
            set_idx_d = set_idx_q + 1'b1;
            state_d   = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: everything below depends on registered state only.
  always_comb begin
    active_o    = (state_q != S_IDLE);
    flush_ack_o = (state_q == S_DONE);
    req_o       = '0;
    we_o        = 1'b0;
    be_o        = '0;
    addr_o      = '0;
    wb_valid_o  = 1'b0;
    wb_addr_o   = '0;
    wb_way_o    = '0;
    if (state_q == S_READ || state_q == S_CLEAR) begin
      req_o  = '1;
      addr_o = {set_idx_q, {BYTE_OFFSET{1'b0}}};
    end
    if (state_q == S_CLEAR) begin
      we_o = 1'b1;
      be_o = '1;
    end
    if (state_q == S_WB) begin
      wb_valid_o = 1'b1;
      wb_way_o   = wb_way;
      wb_addr_o  = {tags_q[wb_way], set_idx_q, {BYTE_OFFSET{1'b0}}};
    end
  end

endmodule
